// File: rtl/ac_pkg.sv
// Shared definitions for the accumulator datapath: default widths,
// the AC operation select encoding and a strobe-count helper.
package ac_pkg;

  localparam int AC_WIDTH  = 16;
  localparam int AC_INPR_W = 8;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_AND,
    OP_ADD,
    OP_LDA,
    OP_COM,
    OP_CIR,
    OP_CIL,
    OP_INP
  } ac_op_t;

  // Number of hot bits in the seven ld-qualified select strobes.
  function automatic logic [2:0] strobe_count(input logic [6:0] sel);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 7; i++) begin
      cnt = cnt + {2'b00, sel[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ac_datapath_alu.sv
// Combinational adder/logic unit: produces the candidate AC value and the
// carry/rotate-out bit for the selected ld-qualified operation.
module ac_datapath_alu
  import ac_pkg::*;
#(
  parameter int WIDTH  = AC_WIDTH,
  parameter int INPR_W = AC_INPR_W
) (
  input  ac_op_t             op,
  input  logic [WIDTH-1:0]   ac,
  input  logic [WIDTH-1:0]   dr,
  input  logic               e,
  input  logic [INPR_W-1:0]  inpr,
  output logic [WIDTH-1:0]   next_ac,
  output logic               next_e_carry
);

  logic [WIDTH:0] sum_ext;

  assign sum_ext = {1'b0, ac} + {1'b0, dr};

  // Operation mux; OP_NONE holds AC and passes E through unchanged.
  always_comb begin
    next_ac      = ac;
    next_e_carry = e;
    case (op)
      OP_AND: next_ac = ac & dr;
      OP_ADD: begin
        next_ac      = sum_ext[WIDTH-1:0];
        next_e_carry = sum_ext[WIDTH];
      end
      OP_LDA: next_ac = dr;
      OP_COM: next_ac = ~ac;
      OP_CIR: begin
        next_ac      = {e, ac[WIDTH-1:1]};
        next_e_carry = ac[0];
      end
      OP_CIL: begin
        next_ac      = {ac[WIDTH-2:0], e};
        next_e_carry = ac[WIDTH-1];
      end
      OP_INP: next_ac = {{(WIDTH-INPR_W){1'b0}}, inpr};
      default: begin
        next_ac      = ac;
        next_e_carry = e;
      end
    endcase
  end

endmodule

// File: rtl/ac_datapath.sv
// Accumulator datapath top: AC, E and status registers plus the strobe
// priority and illegal-combination detection around the ALU.
module ac_datapath
  import ac_pkg::*;
#(
  parameter int WIDTH  = AC_WIDTH,
  parameter int INPR_W = AC_INPR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              and_op,
  input  logic              add_op,
  input  logic              lda_op,
  input  logic              com_op,
  input  logic              cir_op,
  input  logic              cil_op,
  input  logic              inp_op,
  input  logic              ld,
  input  logic              inc_op,
  input  logic              clr_op,
  input  logic              cle_op,
  input  logic              cme_op,
  input  logic [WIDTH-1:0]  dr,
  input  logic [INPR_W-1:0] inpr,
  output logic [WIDTH-1:0]  ac,
  output logic              e,
  output logic              ac_zero,
  output logic              ac_neg,
  output logic              op_err
);

  logic [6:0]       sel;
  logic [2:0]       sel_cnt;
  ac_op_t           op;
  logic [WIDTH-1:0] alu_ac;
  logic             alu_e;
  logic             carry_op;
  logic [WIDTH-1:0] next_ac;
  logic             next_e;
  logic             err_now;

  assign sel     = {and_op, add_op, lda_op, com_op, cir_op, cil_op, inp_op};
  assign sel_cnt = strobe_count(sel);

  // Priority-select the ALU operation; only meaningful while ld is high.
  always_comb begin
    op = OP_NONE;
    if (ld) begin
      if (and_op)      op = OP_AND;
      else if (add_op) op = OP_ADD;
      else if (lda_op) op = OP_LDA;
      else if (com_op) op = OP_COM;
      else if (cir_op) op = OP_CIR;
      else if (cil_op) op = OP_CIL;
      else if (inp_op) op = OP_INP;
      else             op = OP_NONE;
    end
  end

  ac_datapath_alu #(
    .WIDTH  (WIDTH),
    .INPR_W (INPR_W)
  ) u_alu (
    .op           (op),
    .ac           (ac),
    .dr           (dr),
    .e            (e),
    .inpr         (inpr),
    .next_ac      (alu_ac),
    .next_e_carry (alu_e)
  );

  assign carry_op = (op == OP_ADD) || (op == OP_CIR) || (op == OP_CIL);

  // Next AC: clear beats load beats increment beats hold.
  always_comb begin
    next_ac = ac;
    if (clr_op)      next_ac = '0;
    else if (ld)     next_ac = alu_ac;
    else if (inc_op) next_ac = ac + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  // Next E: explicit E strobes beat carry; a clear aborts the ld operation's carry.
  always_comb begin
    next_e = e;
    if (cle_op)                   next_e = 1'b0;
    else if (cme_op)              next_e = ~e;
    else if (carry_op && !clr_op) next_e = alu_e;
  end

  // Illegal strobe combinations for this cycle.
  assign err_now = (ld && (sel_cnt != 3'd1))
                 || (clr_op && (ld || inc_op))
                 || ((cle_op || cme_op) && carry_op);

  // State and status registers; status tracks the value being loaded into AC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac      <= '0;
      e       <= 1'b0;
      ac_zero <= 1'b1;
      ac_neg  <= 1'b0;
      op_err  <= 1'b0;
    end else begin
      ac      <= next_ac;
      e       <= next_e;
      ac_zero <= (next_ac == '0);
      ac_neg  <= next_ac[WIDTH-1];
      op_err  <= op_err | err_now;
    end
  end

endmodule

// File: tb/tb_ac_datapath.sv
// Scoreboard bench for ac_datapath: directed steps push expectations,
// a negedge monitor pops and compares them when their cycle arrives.
module tb_ac_datapath;

  localparam logic [11:0] S_AND = 12'h800;
  localparam logic [11:0] S_ADD = 12'h400;
  localparam logic [11:0] S_LDA = 12'h200;
  localparam logic [11:0] S_COM = 12'h100;
  localparam logic [11:0] S_CIR = 12'h080;
  localparam logic [11:0] S_CIL = 12'h040;
  localparam logic [11:0] S_INP = 12'h020;
  localparam logic [11:0] S_LD  = 12'h010;
  localparam logic [11:0] S_INC = 12'h008;
  localparam logic [11:0] S_CLR = 12'h004;
  localparam logic [11:0] S_CLE = 12'h002;
  localparam logic [11:0] S_CME = 12'h001;

  logic        clk;
  logic        rst;
  logic        and_op, add_op, lda_op, com_op, cir_op, cil_op, inp_op;
  logic        ld, inc_op, clr_op, cle_op, cme_op;
  logic [15:0] dr;
  logic [7:0]  inpr;
  logic [15:0] ac;
  logic        e, ac_zero, ac_neg, op_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    string       name;
    logic [15:0] ac;
    logic        e;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  ac_datapath dut (
    .clk     (clk),
    .rst     (rst),
    .and_op  (and_op),
    .add_op  (add_op),
    .lda_op  (lda_op),
    .com_op  (com_op),
    .cir_op  (cir_op),
    .cil_op  (cil_op),
    .inp_op  (inp_op),
    .ld      (ld),
    .inc_op  (inc_op),
    .clr_op  (clr_op),
    .cle_op  (cle_op),
    .cme_op  (cme_op),
    .dr      (dr),
    .inpr    (inpr),
    .ac      (ac),
    .e       (e),
    .ac_zero (ac_zero),
    .ac_neg  (ac_neg),
    .op_err  (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string name, input logic [15:0] x_ac,
                         input logic x_e, input logic x_err);
    logic x_zero;
    logic x_neg;
    x_zero = (x_ac == 16'h0000);
    x_neg  = x_ac[15];
    checks++;
    if (ac !== x_ac || e !== x_e || ac_zero !== x_zero || ac_neg !== x_neg || op_err !== x_err) begin
      failures++;
      $display("FAIL %s: got ac=%h e=%b zero=%b neg=%b err=%b, want ac=%h e=%b zero=%b neg=%b err=%b",
               name, ac, e, ac_zero, ac_neg, op_err, x_ac, x_e, x_zero, x_neg, x_err);
    end
  endtask

  task automatic set_strobes(input logic [11:0] s);
    {and_op, add_op, lda_op, com_op, cir_op, cil_op, inp_op,
     ld, inc_op, clr_op, cle_op, cme_op} = s;
  endtask

  // One-cycle step: drive at negedge, expect result after the next posedge.
  task automatic step(input string name, input logic [11:0] s,
                      input logic [15:0] d, input logic [7:0] ip,
                      input logic [15:0] x_ac, input logic x_e, input logic x_err);
    exp_t x;
    @(negedge clk);
    set_strobes(s);
    dr   = d;
    inpr = ip;
    x.due  = cyc + 1;
    x.name = name;
    x.ac   = x_ac;
    x.e    = x_e;
    x.err  = x_err;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    set_strobes(12'h000);
  endtask

  // Asynchronous reset applied between edges; outputs must respond at once.
  task automatic async_reset(input string name);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    compare(name, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        exp_t x;
        x = sb_q.pop_front();
        if (x.due < cyc) begin
          checks++;
          failures++;
          $display("FAIL %s: sampled late at cycle %0d, wanted cycle %0d", x.name, cyc, x.due);
        end else begin
          compare(x.name, x.ac, x.e, x.err);
        end
      end
    end
  end

  initial begin
    rst  = 1'b1;
    dr   = 16'h0000;
    inpr = 8'h00;
    set_strobes(12'h000);
    #12;
    compare("reset_state", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step("lda_1234", S_LD | S_LDA, 16'h1234, 8'h00, 16'h1234, 1'b0, 1'b0);
    async_reset("rst_mid_run");

    step("lda_ffff", S_LD | S_LDA, 16'hFFFF, 8'h00, 16'hFFFF, 1'b0, 1'b0);
    step("add_wrap", S_LD | S_ADD, 16'h0001, 8'h00, 16'h0000, 1'b1, 1'b0);

    step("lda_8001", S_LD | S_LDA, 16'h8001, 8'h00, 16'h8001, 1'b1, 1'b0);
    step("cle", S_CLE, 16'h0000, 8'h00, 16'h8001, 1'b0, 1'b0);
    step("cir", S_LD | S_CIR, 16'h0000, 8'h00, 16'h4000, 1'b1, 1'b0);
    step("cil", S_LD | S_CIL, 16'h0000, 8'h00, 16'h8001, 1'b0, 1'b0);

    step("lda_ffff_b", S_LD | S_LDA, 16'hFFFF, 8'h00, 16'hFFFF, 1'b0, 1'b0);
    step("cme", S_CME, 16'h0000, 8'h00, 16'hFFFF, 1'b1, 1'b0);
    step("inc_wrap", S_INC, 16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0);
    step("lda_00f0", S_LD | S_LDA, 16'h00F0, 8'h00, 16'h00F0, 1'b1, 1'b0);
    step("com", S_LD | S_COM, 16'h0000, 8'h00, 16'hFF0F, 1'b1, 1'b0);
    step("sel_no_ld", S_ADD | S_COM, 16'h1111, 8'h00, 16'hFF0F, 1'b1, 1'b0);

    step("lda_0005", S_LD | S_LDA, 16'h0005, 8'h00, 16'h0005, 1'b1, 1'b0);
    step("clr_inc", S_CLR | S_INC, 16'h0000, 8'h00, 16'h0000, 1'b1, 1'b1);
    step("err_sticky", 12'h000, 16'h0000, 8'h00, 16'h0000, 1'b1, 1'b1);
    step("inc_after_err", S_INC, 16'h0000, 8'h00, 16'h0001, 1'b1, 1'b1);

    async_reset("rst_clears_err");
    step("lda_0f0f", S_LD | S_LDA, 16'h0F0F, 8'h00, 16'h0F0F, 1'b0, 1'b0);
    step("and_lda_multi", S_LD | S_AND | S_LDA, 16'h00FF, 8'h00, 16'h000F, 1'b0, 1'b1);
    step("inp_no_ld", S_INP, 16'h0000, 8'hAB, 16'h000F, 1'b0, 1'b1);

    async_reset("rst_2");
    step("ld_no_sel", S_LD, 16'h5555, 8'h00, 16'h0000, 1'b0, 1'b1);

    async_reset("rst_3");
    step("inp", S_LD | S_INP, 16'h0000, 8'hAB, 16'h00AB, 1'b0, 1'b0);
    step("lda_7fff", S_LD | S_LDA, 16'h7FFF, 8'h00, 16'h7FFF, 1'b0, 1'b0);
    step("add_neg", S_LD | S_ADD, 16'h0001, 8'h00, 16'h8000, 1'b0, 1'b0);
    step("add_cle", S_LD | S_ADD | S_CLE, 16'h8000, 8'h00, 16'h0000, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    while (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: expectation never compared (due cycle %0d)", x.name, x.due);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
